// File: rtl/mips_run_pkg.sv
// Shared definitions for the MIPS run controller: FSM state encoding and
// stop-cause codes.
package mips_run_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RESET = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } run_state_e;

  localparam logic [1:0] STOP_NONE  = 2'd0;
  localparam logic [1:0] STOP_BP    = 2'd1;
  localparam logic [1:0] STOP_LIMIT = 2'd2;
  localparam logic [1:0] STOP_ABORT = 2'd3;

endpackage

// File: rtl/mips_bp_match.sv
// PC breakpoint comparators with a lowest-index-wins priority encoder.
module mips_bp_match #(
  parameter int PC_W   = 32,
  parameter int NUM_BP = 2
) (
  input  logic [NUM_BP-1:0]      bp_en,
  input  logic [NUM_BP*PC_W-1:0] bp_addr,
  input  logic [PC_W-1:0]        pc,
  output logic                   hit,
  output logic [2:0]             idx
);

  // Scanning from the top down lets the lowest matching index overwrite.
  always_comb begin
    hit = 1'b0;
    idx = 3'd0;
    for (int i = NUM_BP - 1; i >= 0; i--) begin
      if (bp_en[i] && (bp_addr[i*PC_W +: PC_W] == pc)) begin
        hit = 1'b1;
        idx = 3'(i);
      end
    end
  end

endmodule

// File: rtl/mips_run_ctrl.sv
// Run controller for a MIPS core: holds the core in reset, clocks it via an
// enable, and stops it on a breakpoint, a cycle limit or an abort.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | out of reset, core held in reset until a run starts
//   ST_RESET | core_rst asserted for RST_CYC cycles, run status cleared
//   ST_RUN   | core enabled until a stop condition is seen
//   ST_DONE  | core frozen, stop_cause/hit_idx/cycle_count valid
module mips_run_ctrl
  import mips_run_pkg::*;
#(
  parameter int PC_W    = 32,
  parameter int CNT_W   = 16,
  parameter int NUM_BP  = 2,
  parameter int RST_CYC = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic [CNT_W-1:0]       cycle_limit,
  input  logic [NUM_BP-1:0]      bp_en,
  input  logic [NUM_BP*PC_W-1:0] bp_addr,
  input  logic [PC_W-1:0]        pc_current,
  output logic                   core_rst,
  output logic                   core_run,
  output logic                   busy,
  output logic                   done,
  output logic [1:0]             stop_cause,
  output logic [2:0]             hit_idx,
  output logic [CNT_W-1:0]       cycle_count
);

  localparam int RW = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;

  run_state_e       r_state;
  logic [RW-1:0]    r_rst_cnt;
  logic [CNT_W-1:0] r_cycle_count;
  logic [1:0]       r_stop_cause;
  logic [2:0]       r_hit_idx;
  logic             r_core_rst;
  logic             r_busy;
  logic             r_done;

  logic             w_bp_hit;
  logic [2:0]       w_bp_idx;
  logic             w_lim_hit;
  logic             w_stop_now;
  logic             w_run;

  mips_bp_match #(
    .PC_W   (PC_W),
    .NUM_BP (NUM_BP)
  ) u_bp_match (
    .bp_en   (bp_en),
    .bp_addr (bp_addr),
    .pc      (pc_current),
    .hit     (w_bp_hit),
    .idx     (w_bp_idx)
  );

  assign w_lim_hit  = (cycle_limit != '0) && (r_cycle_count == cycle_limit);
  assign w_stop_now = w_bp_hit | w_lim_hit | abort;
  // Combinational so the core never takes the edge on which it must stop.
  assign w_run      = (r_state == ST_RUN) && !w_stop_now;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_rst_cnt     <= '0;
      r_cycle_count <= '0;
      r_stop_cause  <= STOP_NONE;
      r_hit_idx     <= '0;
      r_core_rst    <= 1'b1;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_state       <= ST_RESET;
            r_rst_cnt     <= RW'(RST_CYC - 1);
            r_cycle_count <= '0;
            r_stop_cause  <= STOP_NONE;
            r_hit_idx     <= '0;
            r_core_rst    <= 1'b1;
            r_busy        <= 1'b1;
            r_done        <= 1'b0;
          end
        end
        ST_RESET: begin
          if (abort) begin
            r_state      <= ST_DONE;
            r_stop_cause <= STOP_ABORT;
            r_core_rst   <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b1;
          end else if (r_rst_cnt == '0) begin
            r_state    <= ST_RUN;
            r_core_rst <= 1'b0;
          end else begin
            r_rst_cnt <= r_rst_cnt - RW'(1);
          end
        end
        ST_RUN: begin
          if (w_run && (r_cycle_count != '1))
            r_cycle_count <= r_cycle_count + CNT_W'(1);
          if (w_stop_now) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            if (w_bp_hit) begin
              r_stop_cause <= STOP_BP;
              r_hit_idx    <= w_bp_idx;
            end else if (w_lim_hit) begin
              r_stop_cause <= STOP_LIMIT;
            end else begin
              r_stop_cause <= STOP_ABORT;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign core_rst    = r_core_rst;
  assign core_run    = w_run;
  assign busy        = r_busy;
  assign done        = r_done;
  assign stop_cause  = r_stop_cause;
  assign hit_idx     = r_hit_idx;
  assign cycle_count = r_cycle_count;

endmodule
